// File: rtl/regfile_access_ctrl.sv
// Register file access controller for the single-cycle core.
// After reset it clears x1..x(NREG-1) while stalling the core. It then passes
// core traffic through to the register file and shares the read and write
// ports with a debug requester through a req/ack handshake. A starvation
// counter forces a debug write through under continuous core writeback.
module regfile_access_ctrl #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  // core side
  input  logic [$clog2(NREG)-1:0]   core_rs1,
  input  logic [$clog2(NREG)-1:0]   core_rs2,
  input  logic [$clog2(NREG)-1:0]   core_rd,
  input  logic [XLEN-1:0]           core_data,
  input  logic                      core_wr,
  output logic                      core_stall,
  output logic                      init_done,
  // debug side
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [$clog2(NREG)-1:0]   dbg_addr,
  input  logic [XLEN-1:0]           dbg_wdata,
  output logic                      dbg_ack,
  output logic [XLEN-1:0]           dbg_rdata,
  // register file side
  output logic [$clog2(NREG)-1:0]   ru_rs1,
  output logic [$clog2(NREG)-1:0]   ru_rs2,
  output logic [$clog2(NREG)-1:0]   ru_rd,
  output logic [XLEN-1:0]           ru_datawr,
  output logic                      ru_wr,
  input  logic [XLEN-1:0]           ru_rs1_data
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] IDX_FIRST  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NREG - 1);
  localparam logic [AW-1:0] REG_ZERO   = AW'(0);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   idx_r;
  logic [AW-1:0]   idx_nxt_s;
  logic [SW-1:0]   starve_r;
  logic [SW-1:0]   starve_nxt_s;
  logic            dbg_ack_r;
  logic [XLEN-1:0] dbg_rdata_r;
  logic            init_done_r;
  logic            grant_s;
  logic            rd_grant_s;
  logic            core_wb_s;

  assign dbg_ack   = dbg_ack_r;
  assign dbg_rdata = dbg_rdata_r;
  assign init_done = init_done_r;

  // Next-state, debug arbitration and register file port steering.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    starve_nxt_s = starve_r;
    grant_s      = 1'b0;
    rd_grant_s   = 1'b0;
    core_wb_s    = core_wr && (core_rd != REG_ZERO);
    ru_rs1       = core_rs1;
    ru_rs2       = core_rs2;
    ru_rd        = core_rd;
    ru_datawr    = core_data;
    ru_wr        = core_wb_s;
    core_stall   = 1'b0;

    case (state_r)
      ST_INIT: begin
        // Clear sequence: one register per cycle, debug requests ignored.
        ru_rd      = idx_r;
        ru_datawr  = {XLEN{1'b0}};
        ru_wr      = 1'b1;
        core_stall = 1'b1;
        idx_nxt_s  = idx_r + AW'(1);
        if (idx_r == IDX_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (dbg_req) begin
          if (!dbg_we) begin
            // Reads always win: stall the core and borrow the rs1 port.
            grant_s    = 1'b1;
            rd_grant_s = 1'b1;
            core_stall = 1'b1;
            ru_rs1     = dbg_addr;
            ru_wr      = 1'b0;
          end else if (!core_wb_s || (starve_r == STARVE_MAX)) begin
            // Free write port, or the debug write has waited long enough.
            grant_s    = 1'b1;
            core_stall = core_wb_s;
            ru_rd      = dbg_addr;
            ru_datawr  = dbg_wdata;
            ru_wr      = (dbg_addr != REG_ZERO);
          end else begin
            // Core writeback keeps the port; remember the denial.
            starve_nxt_s = starve_r + SW'(1);
          end
        end else begin
          starve_nxt_s = starve_r;
        end
        if (grant_s) begin
          starve_nxt_s = {SW{1'b0}};
          state_nxt_s  = ST_ACK;
        end else begin
          state_nxt_s  = ST_RUN;
        end
      end
      ST_ACK: begin
        // Passthrough only; the request is being withdrawn this cycle.
        state_nxt_s = ST_RUN;
      end
      default: begin
        ru_wr       = 1'b0;
        core_stall  = 1'b1;
        state_nxt_s = ST_INIT;
        idx_nxt_s   = IDX_FIRST;
      end
    endcase

    // Reset dominates: no writes, core held, nothing granted.
    if (RST) begin
      ru_wr      = 1'b0;
      core_stall = 1'b1;
      grant_s    = 1'b0;
      rd_grant_s = 1'b0;
    end else begin
      grant_s    = grant_s;
      rd_grant_s = rd_grant_s;
    end
  end

  // State, clear index, starvation counter and registered debug outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_INIT;
      idx_r       <= IDX_FIRST;
      starve_r    <= {SW{1'b0}};
      dbg_ack_r   <= 1'b0;
      dbg_rdata_r <= {XLEN{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      starve_r  <= starve_nxt_s;
      dbg_ack_r <= grant_s;
      if (rd_grant_s) begin
        dbg_rdata_r <= ru_rs1_data;
      end
      if ((state_r == ST_INIT) && (state_nxt_s == ST_RUN)) begin
        init_done_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl: directed scenarios followed by random
// core/debug traffic, checked against an architectural register model and a
// scoreboard of expected debug acknowledges.
module tb_regfile_access_ctrl;

  localparam int STARVE_LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  core_rs1, core_rs2, core_rd;
  logic [31:0] core_data;
  logic        core_wr;
  logic        core_stall, init_done;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [4:0]  ru_rs1, ru_rs2, ru_rd;
  logic [31:0] ru_datawr;
  logic        ru_wr;
  logic [31:0] ru_rs1_data;

  regfile_access_ctrl #(.XLEN(32), .NREG(32), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd(core_rd),
    .core_data(core_data), .core_wr(core_wr),
    .core_stall(core_stall), .init_done(init_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ru_rs1(ru_rs1), .ru_rs2(ru_rs2), .ru_rd(ru_rd),
    .ru_datawr(ru_datawr), .ru_wr(ru_wr), .ru_rs1_data(ru_rs1_data)
  );

  always #5 CLK = ~CLK;

  // Register file behind the controller; x0 reads as zero.
  logic [31:0] rf [32];
  always @(posedge CLK) if (ru_wr) rf[ru_rd] <= ru_datawr;
  assign ru_rs1_data = (ru_rs1 == 5'd0) ? 32'd0 : rf[ru_rs1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected acknowledges.
  typedef struct {
    bit          we;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  logic [31:0] arch [32];
  int          m_init_left = 31;
  int          m_idx = 1;
  bit          m_pending = 1'b0;
  bit          m_we = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_wdata = 32'd0;
  int          m_denials = 0;
  bit          m_ack_next = 1'b0;

  task automatic issue(input bit we, input logic [4:0] a, input logic [31:0] d);
    m_pending = 1'b1; m_we = we; m_addr = a; m_wdata = d; m_denials = 0;
  endtask

  // One clock cycle: drive inputs, predict, check combinational outputs.
  task automatic step(input bit rst_i, input bit cwr, input logic [4:0] crd, input logic [31:0] cdata);
    bit          ack_now, grant, stall_e, wr_e, contention;
    logic [4:0]  rd_e, rs1_e;
    logic [31:0] dw_e;
    @(negedge CLK);
    RST = rst_i; core_wr = cwr; core_rd = crd; core_data = cdata;
    core_rs1 = 5'($urandom); core_rs2 = 5'($urandom);
    dbg_req = m_pending; dbg_we = m_we; dbg_addr = m_addr; dbg_wdata = m_wdata;
    #1;
    ack_now = m_ack_next; m_ack_next = 1'b0;
    grant = 1'b0; stall_e = 1'b0;
    contention = cwr && (crd != 5'd0);
    rs1_e = core_rs1; rd_e = crd; dw_e = cdata; wr_e = contention;
    if (rst_i) begin
      chk("rst_stall", core_stall, 32'd1);
      chk("rst_wr", ru_wr, 32'd0);
      m_init_left = 31; m_idx = 1; m_pending = 1'b0; m_denials = 0;
      for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    end else if (m_init_left > 0) begin
      if (m_idx == 1) begin
        chk("rst_ack", dbg_ack, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
      end
      chk("init_wr", ru_wr, 32'd1);
      chk("init_rd", ru_rd, 32'(m_idx));
      chk("init_data", ru_datawr, 32'd0);
      chk("init_stall", core_stall, 32'd1);
      chk("init_done_lo", init_done, 32'd0);
      chk("init_rs1", ru_rs1, rs1_e);
      m_idx++; m_init_left--;
    end else begin
      if (m_pending && !ack_now) begin
        if (!m_we) begin
          grant = 1'b1; stall_e = 1'b1; rs1_e = m_addr; wr_e = 1'b0;
        end else if (!contention || m_denials == STARVE_LIMIT) begin
          grant = 1'b1; stall_e = contention;
          rd_e = m_addr; dw_e = m_wdata; wr_e = (m_addr != 5'd0);
        end else begin
          m_denials++;
        end
      end
      chk("init_done_hi", init_done, 32'd1);
      chk("stall", core_stall, 32'(stall_e));
      chk("ru_wr", ru_wr, 32'(wr_e));
      chk("ru_rs1", ru_rs1, rs1_e);
      chk("ru_rs2", ru_rs2, core_rs2);
      if (wr_e) begin
        chk("ru_rd", ru_rd, rd_e);
        chk("ru_datawr", ru_datawr, dw_e);
      end
      if (grant) begin
        exp_q.push_back('{we: m_we, rdata: (m_we ? 32'd0 : arch[m_addr]), cyc: cyc + 1});
        if (m_we && m_addr != 5'd0) arch[m_addr] = m_wdata;
        m_pending = 1'b0; m_denials = 0; m_ack_next = 1'b1;
      end else if (contention) begin
        arch[crd] = cdata;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'($urandom), $urandom);
  endtask

  // Monitor: every acknowledge must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (dbg_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.we) chk("dbg_rdata", dbg_rdata, e.rdata);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    RST = 1'b1; core_wr = 1'b0; core_rd = 5'd0; core_data = 32'd0;
    core_rs1 = 5'd0; core_rs2 = 5'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      arch[i] = 32'd0;
    end

    // Reset, clear sequence, then read of x7 after the clear.
    step(1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0);
    repeat (31) idle();
    repeat (2) idle();
    issue(1'b0, 5'd7, 32'd0);
    repeat (2) idle();

    // Idle core: debug write x5, then read it back.
    issue(1'b1, 5'd5, 32'hDEADBEEF);
    repeat (2) idle();
    issue(1'b0, 5'd5, 32'd0);
    repeat (2) idle();

    // Continuous core writeback to x3 against a debug write to x9.
    issue(1'b1, 5'd9, 32'h12345678);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 5'd3, $urandom);

    // Core writeback to x0 does not block a debug write to x2.
    issue(1'b1, 5'd2, 32'hA5A55A5A);
    step(1'b0, 1'b1, 5'd0, $urandom);
    idle();

    // Debug write to x0 is acknowledged but never written; read x0.
    issue(1'b1, 5'd0, 32'hFFFFFFFF);
    repeat (2) idle();
    issue(1'b0, 5'd0, 32'd0);
    repeat (2) idle();
    issue(1'b0, 5'd2, 32'd0);
    repeat (2) idle();

    // Reset in the middle of the clear (idx 12).
    step(1'b1, 1'b0, 5'd0, 32'd0);
    repeat (11) idle();
    step(1'b1, 1'b0, 5'd0, 32'd0);
    repeat (33) idle();

    // Reset in the cycle a debug write would be granted.
    issue(1'b1, 5'd6, 32'h0BADF00D);
    step(1'b1, 1'b0, 5'd0, 32'd0);
    repeat (33) idle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (!m_pending && !m_ack_next && $urandom_range(0, 2) == 0)
        issue(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      step($urandom_range(0, 799) == 0, $urandom_range(0, 3) != 0, 5'($urandom), $urandom);
    end
    repeat (40) idle();

    for (int i = 1; i < 32; i++) chk("rf_final", rf[i], arch[i]);
    chk("acks_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
